seq_mul_param: RTL and testbench

//  Parametrised shift-add sequential multiplier; successor to the fixed 4-bit seq_mul.

---
 rtl/seq_mul_pkg.sv | 7 +
 rtl/seq_mul_negate.sv | 13 +
 rtl/seq_mul_param.sv | 79 +++++++
 tb/tb_seq_mul_param.sv | 109 ++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM state type and counter sizing for the sequential multiplier
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_mul_negate.sv
// seq_mul_negate: conditional two's-complement negate
//   en_i  negate when high
//   x_i   input value (N bits)
//   y_o   en_i ? -x_i : x_i
module seq_mul_negate #(
  parameter int N = 4
) (
  input  logic         en_i,
  input  logic [N-1:0] x_i,
  output logic [N-1:0] y_o
);
  assign y_o = en_i ? -x_i : x_i;
endmodule

// File: rtl/seq_mul_param.sv
// seq_mul_param: parametrised shift-add sequential multiplier, signed or unsigned per operation
//   clk, rst     clock, synchronous active-high reset
//   start        request, sampled when busy is low
//   signed_mode  two's-complement operands/result when high, sampled with start
//   a, b         multiplicand and multiplier, sampled with start
//   busy         high while the shift-add loop runs
//   done         one-cycle pulse when product is updated
//   product      2*WIDTH-bit result, held until the next done
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = cnt_w(WIDTH);
  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, product_q, acc_d, res_d;
  logic [WIDTH-1:0]   mplier_q, mag_a, mag_b;
  logic [CW-1:0]      count_q;
  logic               neg_q, busy_q, done_q;
  seq_mul_negate #(.N(WIDTH)) u_mag_a (.en_i(signed_mode & a[WIDTH-1]), .x_i(a), .y_o(mag_a));
  seq_mul_negate #(.N(WIDTH)) u_mag_b (.en_i(signed_mode & b[WIDTH-1]), .x_i(b), .y_o(mag_b));
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  // Sign fix uses the accumulator including the final iteration so product lands on the done edge.
  seq_mul_negate #(.N(2*WIDTH)) u_fix (.en_i(neg_q), .x_i(acc_d), .y_o(res_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= start ? CALC : IDLE;
          busy_q  <= start;
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            count_q  <= '0;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= res_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_seq_mul_param.sv
// tb_seq_mul_param: directed and random checks of seq_mul_param at WIDTH=4 and WIDTH=8
module tb_seq_mul_param;
  logic clk = 1'b0, rst = 1'b1;
  logic st4 = 1'b0, sm4 = 1'b0, st8 = 1'b0, sm8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy4, done4, busy8, done8;
  logic [7:0] product4;
  logic [15:0] product8;
  int cmp = 0, mis = 0;
  always #5 clk = ~clk;
  seq_mul_param #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4));
  seq_mul_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8));
  function automatic logic [63:0] ref_mul(input int w, input logic sm, input int x, input int y);
    longint va = x, vb = y;
    if (sm && x >= (1 << (w - 1))) va = x - (1 << w);
    if (sm && y >= (1 << (w - 1))) vb = y - (1 << w);
    return (va * vb) & ((64'sd1 <<< (2 * w)) - 1);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Caller sits at a negedge; start is raised here and sampled on the next posedge.
  task automatic run4(input logic sm, input logic [3:0] x, input logic [3:0] y, input bit noise, input string tag);
    logic [7:0] prev = product4;
    int lat = 0, nb = 0;
    sm4 = sm; a4 = x; b4 = y; st4 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      st4 = noise && k == 2;
      if (noise) begin sm4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); end
      if (k == 1) chk({tag, " hold"}, 64'(product4), 64'(prev));
      if (done4) begin lat = k; break; end
      nb += int'(busy4);
    end
    chk({tag, " latency"}, 64'(lat), 64'd5);
    chk({tag, " busy cycles"}, 64'(nb), 64'd4);
    chk({tag, " busy at done"}, 64'(busy4), 64'd0);
    chk({tag, " product"}, 64'(product4), ref_mul(4, sm, int'(x), int'(y)));
  endtask
  task automatic run8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    int lat = 0;
    sm8 = sm; a8 = x; b8 = y; st8 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      st8 = 1'b0;
      if (done8) begin lat = k; break; end
    end
    chk("w8 latency", 64'(lat), 64'd9);
    chk("w8 product", 64'(product8), ref_mul(8, sm, int'(x), int'(y)));
  endtask
  initial begin
    int dn;
    repeat (2) @(negedge clk);
    chk("reset busy4", 64'(busy4), 64'd0);
    chk("reset done4", 64'(done4), 64'd0);
    chk("reset product4", 64'(product4), 64'd0);
    chk("reset product8", 64'(product8), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run4(1'b0, 4'd3, 4'd2, 1'b0, "3x2");
    @(negedge clk);
    chk("done pulse width", 64'(done4), 64'd0);
    run4(1'b0, 4'hF, 4'hF, 1'b0, "15x15");
    @(negedge clk);
    run4(1'b1, 4'h8, 4'h8, 1'b0, "-8x-8");
    @(negedge clk);
    run4(1'b1, 4'hD, 4'h5, 1'b0, "-3x5");
    @(negedge clk);
    run4(1'b1, 4'h0, 4'h9, 1'b0, "0x-7");
    run4(1'b0, 4'h7, 4'h7, 1'b0, "b2b 7x7");
    run4(1'b1, 4'hA, 4'h3, 1'b1, "noise -6x3");
    @(negedge clk);
    sm4 = 1'b0; a4 = 4'd5; b4 = 4'd5; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    st4 = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy4), 64'd0);
    chk("abort product", 64'(product4), 64'd0);
    chk("abort done", 64'(done4), 64'd0);
    rst = 1'b0; st4 = 1'b0;
    dn = 0;
    repeat (8) begin @(negedge clk); dn += int'(done4) + int'(busy4); end
    chk("abort no done, dropped start", 64'(dn), 64'd0);
    run4(1'b0, 4'd3, 4'd2, 1'b0, "after abort 3x2");
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run8(1'($urandom), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    run8(1'b1, 8'h80, 8'h80);
    @(negedge clk);
    run8(1'b1, 8'h80, 8'h7F);
    @(negedge clk);
    run8(1'b0, 8'hFF, 8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
